// File: rtl/ddr3_byte_packer_if.sv
//------------------------------------------------------------------------------
// Module   : ddr3_byte_packer_if
// Brief    : Byte-serial DDR3 upload stream plus DDRAM Avalon write port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ddr3_byte_packer_if;
   logic [27:0] ddr3_addr;
   logic [7:0]  ddr3_din;
   logic        ddr3_upload;
   logic        ddr3_wr;
   logic        ddr3_ready;

   logic [24:0] ddram_addr;
   logic [63:0] ddram_din;
   logic [7:0]  ddram_be;
   logic        ddram_we;
   logic [7:0]  ddram_burstcnt;
   logic        ddram_busy;

   // Environment side: byte source upstream and memory controller downstream.
   modport master (
      output ddr3_addr, ddr3_din, ddr3_upload, ddr3_wr,
      input  ddr3_ready,
      input  ddram_addr, ddram_din, ddram_be, ddram_we, ddram_burstcnt,
      output ddram_busy
   );

   // Packer side.
   modport slave (
      input  ddr3_addr, ddr3_din, ddr3_upload, ddr3_wr,
      output ddr3_ready,
      output ddram_addr, ddram_din, ddram_be, ddram_we, ddram_burstcnt,
      input  ddram_busy
   );
endinterface

`default_nettype wire

// File: rtl/ddr3_byte_packer.sv
//------------------------------------------------------------------------------
// Module   : ddr3_byte_packer
// Brief    : Packs a byte-serial upload stream into 64-bit DDRAM single-beat
//            writes with byte enables.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_byte_packer #(
   parameter int WORD_CNT_W = 16
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   ddr3_byte_packer_if.slave          bus,
   output logic [WORD_CNT_W-1:0]      words_written
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_ready;
   logic                  r_we;
   logic                  r_upload_d;
   logic [63:0]           r_buf_data;
   logic [7:0]            r_buf_be;
   logic [24:0]           r_buf_addr;
   logic                  r_pend_valid;
   logic [27:0]           r_pend_addr;
   logic [7:0]            r_pend_data;
   logic [WORD_CNT_W-1:0] r_words;

   logic                  w_accept;
   logic [2:0]            w_lane;
   logic [24:0]           w_word;
   logic                  w_same_word;
   logic [7:0]            w_lane_bit;
   logic [7:0]            w_merged_be;
   logic                  w_upload_rise;

   assign w_accept      = bus.ddr3_wr & r_ready;
   assign w_lane        = bus.ddr3_addr[2:0];
   assign w_word        = bus.ddr3_addr[27:3];
   assign w_same_word   = (r_buf_be == 8'h00) || (w_word == r_buf_addr);
   assign w_lane_bit    = 8'd1 << w_lane;
   assign w_merged_be   = r_buf_be | w_lane_bit;
   assign w_upload_rise = bus.ddr3_upload & ~r_upload_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ready      <= 1'b0;
         r_we         <= 1'b0;
         r_upload_d   <= 1'b0;
         r_buf_data   <= 64'd0;
         r_buf_be     <= 8'd0;
         r_buf_addr   <= 25'd0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= 28'd0;
         r_pend_data  <= 8'd0;
         r_words      <= '0;
      end else begin
         r_upload_d <= bus.ddr3_upload;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b0;
               r_we    <= 1'b0;
               if (w_upload_rise) begin
                  r_buf_be <= 8'd0;
                  r_ready  <= 1'b1;
                  r_state  <= S_COLLECT;
               end
            end

            S_COLLECT: begin
               if (w_accept) begin
                  if (w_same_word) begin
                     r_buf_data[{w_lane, 3'b000} +: 8] <= bus.ddr3_din;
                     r_buf_be   <= w_merged_be;
                     r_buf_addr <= w_word;
                     // Merge first; a simultaneous upload fall still flushes the merged word.
                     if (w_merged_be == 8'hFF || !bus.ddr3_upload) begin
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                        r_state <= S_FLUSH;
                     end
                  end else begin
                     r_pend_valid <= 1'b1;
                     r_pend_addr  <= bus.ddr3_addr;
                     r_pend_data  <= bus.ddr3_din;
                     r_ready      <= 1'b0;
                     r_we         <= 1'b1;
                     r_state      <= S_FLUSH;
                  end
               end else if (!bus.ddr3_upload) begin
                  r_ready <= 1'b0;
                  if (r_buf_be != 8'h00) begin
                     r_we    <= 1'b1;
                     r_state <= S_FLUSH;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end

            S_FLUSH: begin
               r_ready <= 1'b0;
               if (!r_we) begin
                  // Second pass: the word loaded from pend after the session ended.
                  r_we <= 1'b1;
               end else if (!bus.ddram_busy) begin
                  r_we     <= 1'b0;
                  r_words  <= r_words + 1'b1;
                  r_buf_be <= 8'd0;
                  if (r_pend_valid) begin
                     r_pend_valid <= 1'b0;
                     r_buf_data[{r_pend_addr[2:0], 3'b000} +: 8] <= r_pend_data;
                     r_buf_be   <= 8'd1 << r_pend_addr[2:0];
                     r_buf_addr <= r_pend_addr[27:3];
                  end
                  if (bus.ddr3_upload) begin
                     r_ready <= 1'b1;
                     r_state <= S_COLLECT;
                  end else if (r_pend_valid) begin
                     r_state <= S_FLUSH;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ddr3_ready     = r_ready;
   assign bus.ddram_we       = r_we;
   assign bus.ddram_addr     = r_buf_addr;
   assign bus.ddram_din      = r_buf_data;
   assign bus.ddram_be       = r_buf_be;
   assign bus.ddram_burstcnt = 8'd1;
   assign words_written      = r_words;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_byte_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_ddr3_byte_packer
// Brief    : Directed self-checking bench for ddr3_byte_packer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_byte_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] words_written;

   always #5 clk = ~clk;

   ddr3_byte_packer_if bus ();

   ddr3_byte_packer #(.WORD_CNT_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .words_written (words_written)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [24:0] q_addr[$];
   logic [63:0] q_din[$];
   logic [7:0]  q_be[$];

   // Completed DDRAM writes, captured at the accepting edge.
   always @(posedge clk) begin
      if (!reset && bus.ddram_we === 1'b1 && bus.ddram_busy === 1'b0) begin
         q_addr.push_back(bus.ddram_addr);
         q_din.push_back(bus.ddram_din);
         q_be.push_back(bus.ddram_be);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_addr.delete();
      q_din.delete();
      q_be.delete();
   endtask

   task automatic send_byte(input logic [27:0] a, input logic [7:0] d);
      int waited = 0;
      while (bus.ddr3_ready !== 1'b1 && waited < 64) begin
         tick();
         waited++;
      end
      if (bus.ddr3_ready !== 1'b1) begin
         n_total++;
         $display("FAIL send_byte_ready addr=%h: ready=%b, required 1", a, bus.ddr3_ready);
      end else begin
         bus.ddr3_addr = a;
         bus.ddr3_din  = d;
         bus.ddr3_wr   = 1'b1;
         tick();
         bus.ddr3_wr   = 1'b0;
      end
   endtask

   task automatic wait_writes(input int n, input string tag);
      int c = 0;
      while (q_addr.size() < n && c < 200) begin
         tick();
         c++;
      end
      n_total++;
      if (q_addr.size() >= n) n_pass++;
      else $display("FAIL %s_wait: writes=%0d, required %0d", tag, q_addr.size(), n);
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      bus.ddr3_addr   = 28'd0;
      bus.ddr3_din    = 8'd0;
      bus.ddr3_upload = 1'b0;
      bus.ddr3_wr     = 1'b0;
      bus.ddram_busy  = 1'b0;
      repeat (3) tick();
      n_total++; if (bus.ddr3_ready !== 1'b0) $display("FAIL rst_ready: %b, required 0", bus.ddr3_ready); else n_pass++;
      n_total++; if (bus.ddram_we !== 1'b0) $display("FAIL rst_we: %b, required 0", bus.ddram_we); else n_pass++;
      n_total++; if (bus.ddram_be !== 8'h00) $display("FAIL rst_be: %h, required 00", bus.ddram_be); else n_pass++;
      n_total++; if (bus.ddram_din !== 64'd0) $display("FAIL rst_din: %h, required 0", bus.ddram_din); else n_pass++;
      n_total++; if (bus.ddram_addr !== 25'd0) $display("FAIL rst_addr: %h, required 0", bus.ddram_addr); else n_pass++;
      n_total++; if (words_written !== 16'd0) $display("FAIL rst_words: %0d, required 0", words_written); else n_pass++;
      n_total++; if (bus.ddram_burstcnt !== 8'd1) $display("FAIL rst_burstcnt: %h, required 01", bus.ddram_burstcnt); else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_word();
      clear_q();
      bus.ddr3_upload = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) send_byte(28'h1400000 + 28'(j), 8'(j));
      wait_writes(1, "full");
      repeat (2) tick();
      n_total++; if (q_addr.size() != 1) $display("FAIL full_count: %0d writes, required 1", q_addr.size()); else n_pass++;
      if (q_addr.size() >= 1) begin
         n_total++; if (q_addr[0] !== 25'h0280000) $display("FAIL full_addr: %h, required 0280000", q_addr[0]); else n_pass++;
         n_total++; if (q_din[0] !== 64'h0706050403020100) $display("FAIL full_din: %h, required 0706050403020100", q_din[0]); else n_pass++;
         n_total++; if (q_be[0] !== 8'hFF) $display("FAIL full_be: %h, required FF", q_be[0]); else n_pass++;
      end
      n_total++; if (words_written !== 16'd1) $display("FAIL full_words: %0d, required 1", words_written); else n_pass++;
      n_total++; if (bus.ddr3_ready !== 1'b1) $display("FAIL full_ready_back: %b, required 1", bus.ddr3_ready); else n_pass++;
   endtask

   task automatic test_partial_end();
      clear_q();
      send_byte(28'h1400008, 8'hAA);
      send_byte(28'h1400009, 8'hBB);
      send_byte(28'h140000A, 8'hCC);
      bus.ddr3_upload = 1'b0;
      wait_writes(1, "partial");
      if (q_addr.size() >= 1) begin
         n_total++; if (q_addr[0] !== 25'h0280001) $display("FAIL partial_addr: %h, required 0280001", q_addr[0]); else n_pass++;
         n_total++; if (q_be[0] !== 8'h07) $display("FAIL partial_be: %h, required 07", q_be[0]); else n_pass++;
         n_total++; if (q_din[0][23:0] !== 24'hCCBBAA) $display("FAIL partial_din: %h, required CCBBAA", q_din[0][23:0]); else n_pass++;
      end
      repeat (2) tick();
      n_total++; if (bus.ddr3_ready !== 1'b0) $display("FAIL partial_idle_ready: %b, required 0", bus.ddr3_ready); else n_pass++;
      n_total++; if (words_written !== 16'd2) $display("FAIL partial_words: %0d, required 2", words_written); else n_pass++;
      // Strobe while not ready must be ignored.
      bus.ddr3_addr = 28'h1400018;
      bus.ddr3_din  = 8'h99;
      bus.ddr3_wr   = 1'b1;
      tick();
      bus.ddr3_wr   = 1'b0;
      repeat (3) tick();
      n_total++; if (q_addr.size() != 1 || bus.ddram_we !== 1'b0) $display("FAIL ignored_wr: writes=%0d we=%b, required 1 and 0", q_addr.size(), bus.ddram_we); else n_pass++;
      n_total++; if (bus.ddr3_ready !== 1'b0) $display("FAIL ignored_wr_ready: %b, required 0", bus.ddr3_ready); else n_pass++;
   endtask

   task automatic test_word_change();
      clear_q();
      bus.ddr3_upload = 1'b1;
      tick();
      send_byte(28'h1400003, 8'h11);
      send_byte(28'h1400010, 8'h22);
      wait_writes(1, "wchg");
      if (q_addr.size() >= 1) begin
         n_total++; if (q_addr[0] !== 25'h0280000) $display("FAIL wchg_addr0: %h, required 0280000", q_addr[0]); else n_pass++;
         n_total++; if (q_be[0] !== 8'h08) $display("FAIL wchg_be0: %h, required 08", q_be[0]); else n_pass++;
         n_total++; if (q_din[0][31:24] !== 8'h11) $display("FAIL wchg_din0: %h, required 11", q_din[0][31:24]); else n_pass++;
      end
      repeat (3) tick();
      n_total++; if (q_addr.size() != 1) $display("FAIL wchg_held: %0d writes, required 1", q_addr.size()); else n_pass++;
      bus.ddr3_upload = 1'b0;
      wait_writes(2, "wchg2");
      if (q_addr.size() >= 2) begin
         n_total++; if (q_addr[1] !== 25'h0280002) $display("FAIL wchg_addr1: %h, required 0280002", q_addr[1]); else n_pass++;
         n_total++; if (q_be[1] !== 8'h01) $display("FAIL wchg_be1: %h, required 01", q_be[1]); else n_pass++;
         n_total++; if (q_din[1][7:0] !== 8'h22) $display("FAIL wchg_din1: %h, required 22", q_din[1][7:0]); else n_pass++;
      end
      tick();
      n_total++; if (words_written !== 16'd4) $display("FAIL wchg_words: %0d, required 4", words_written); else n_pass++;
   endtask

   task automatic test_busy_hold();
      int c = 0;
      clear_q();
      bus.ddram_busy  = 1'b1;
      bus.ddr3_upload = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) send_byte(28'h1400020 + 28'(j), 8'h40 + 8'(j));
      while (bus.ddram_we !== 1'b1 && c < 20) begin tick(); c++; end
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (bus.ddram_we !== 1'b1 || bus.ddram_addr !== 25'h0280004 || bus.ddram_din !== 64'h4746454443424140 ||
             bus.ddram_be !== 8'hFF || bus.ddr3_ready !== 1'b0)
            $display("FAIL busy_hold[%0d]: we=%b addr=%h din=%h be=%h ready=%b, required 1 0280004 4746454443424140 FF 0",
                     i, bus.ddram_we, bus.ddram_addr, bus.ddram_din, bus.ddram_be, bus.ddr3_ready);
         else n_pass++;
         if (i == 5) bus.ddram_busy = 1'b0;
         tick();
      end
      n_total++; if (bus.ddram_we !== 1'b0 || q_addr.size() != 1) $display("FAIL busy_done: we=%b writes=%0d, required 0 and 1", bus.ddram_we, q_addr.size()); else n_pass++;
      n_total++; if (words_written !== 16'd5) $display("FAIL busy_words: %0d, required 5", words_written); else n_pass++;
      bus.ddr3_upload = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] w0;
      logic [15:0] delta;
      logic [63:0] exp_din;
      int          bad_be = 0, bad_addr = 0, bad_din = 0;
      clear_q();
      w0 = words_written;
      bus.ddr3_upload = 1'b1;
      tick();
      for (int i = 0; i < 2048; i++) send_byte(28'h1400000 + 28'(i), 8'(i));
      wait_writes(256, "b2b");
      repeat (3) tick();
      delta = words_written - w0;
      n_total++; if (delta !== 16'd256) $display("FAIL b2b_words: %0d, required 256", delta); else n_pass++;
      n_total++; if (q_addr.size() != 256) $display("FAIL b2b_count: %0d, required 256", q_addr.size()); else n_pass++;
      for (int k = 0; k < q_addr.size(); k++) begin
         for (int j = 0; j < 8; j++) exp_din[8*j +: 8] = 8'(8*k + j);
         if (q_be[k] !== 8'hFF) bad_be++;
         if (q_addr[k] !== 25'h0280000 + 25'(k)) bad_addr++;
         if (q_din[k] !== exp_din) bad_din++;
      end
      n_total++; if (bad_be != 0) $display("FAIL b2b_be: %0d words not FF, required 0", bad_be); else n_pass++;
      n_total++; if (bad_addr != 0) $display("FAIL b2b_addr: %0d words misaddressed, required 0", bad_addr); else n_pass++;
      n_total++; if (bad_din != 0) $display("FAIL b2b_din: %0d words with wrong data, required 0", bad_din); else n_pass++;
      bus.ddr3_upload = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_in_flush();
      int c = 0;
      clear_q();
      bus.ddram_busy  = 1'b1;
      bus.ddr3_upload = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) send_byte(28'h1400040 + 28'(j), 8'hE0 + 8'(j));
      while (bus.ddram_we !== 1'b1 && c < 20) begin tick(); c++; end
      n_total++; if (bus.ddram_we !== 1'b1) $display("FAIL rif_we_up: %b, required 1", bus.ddram_we); else n_pass++;
      reset = 1'b1;
      tick();
      n_total++; if (bus.ddram_we !== 1'b0) $display("FAIL rif_we: %b, required 0", bus.ddram_we); else n_pass++;
      n_total++; if (bus.ddr3_ready !== 1'b0) $display("FAIL rif_ready: %b, required 0", bus.ddr3_ready); else n_pass++;
      n_total++; if (words_written !== 16'd0) $display("FAIL rif_words: %0d, required 0", words_written); else n_pass++;
      reset           = 1'b0;
      bus.ddr3_upload = 1'b0;
      bus.ddram_busy  = 1'b0;
      repeat (2) tick();
      n_total++; if (q_addr.size() != 0) $display("FAIL rif_discard: %0d writes, required 0", q_addr.size()); else n_pass++;
      bus.ddr3_upload = 1'b1;
      tick();
      send_byte(28'h1400100, 8'h55);
      bus.ddr3_upload = 1'b0;
      wait_writes(1, "rif");
      if (q_addr.size() >= 1) begin
         n_total++; if (q_addr[0] !== 25'h0280020) $display("FAIL rif_addr: %h, required 0280020", q_addr[0]); else n_pass++;
         n_total++; if (q_be[0] !== 8'h01) $display("FAIL rif_be: %h, required 01", q_be[0]); else n_pass++;
         n_total++; if (q_din[0][7:0] !== 8'h55) $display("FAIL rif_din: %h, required 55", q_din[0][7:0]); else n_pass++;
      end
      tick();
      n_total++; if (words_written !== 16'd1) $display("FAIL rif_words_after: %0d, required 1", words_written); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial_end();
      test_word_change();
      test_busy_hold();
      test_back_to_back();
      test_reset_in_flush();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
